// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port word memory between an instruction-fetch
// port (I) and a load/store port (D); one registered response per accepted access.
module mem_arbiter #(
  parameter int MEM_WORDS = 1024,
  parameter int AW        = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_req,
  input  logic [AW-1:0] i_addr,
  output logic          i_gnt,
  output logic          i_rvalid,
  output logic [31:0]   i_rdata,
  output logic          i_err,
  input  logic          d_req,
  input  logic          d_we,
  input  logic [AW-1:0] d_addr,
  input  logic [31:0]   d_wdata,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [31:0]   d_rdata,
  output logic          d_err,
  output logic          mem_read,
  output logic          mem_write,
  output logic [31:0]   mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic [31:0]   mem_rdata,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  typedef enum logic {PORT_I, PORT_D} port_t;

  state_t        state, state_nxt;
  port_t         last, win, pick;
  logic          we_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q;
  logic [31:0]   rdata_q;
  logic          err_q;
  logic [AW-1:0] idx;
  logic          acc_err;

  // The whole byte address takes part in the range check, so high bits never alias.
  assign idx     = addr_q >> 2;
  assign acc_err = (addr_q[1:0] != 2'b00) || (idx >= AW'(MEM_WORDS));

  // A tie goes to the port that did not win the previous tie.
  always_comb begin
    if (i_req && d_req) pick = (last == PORT_D) ? PORT_I : PORT_D;
    else if (i_req)     pick = PORT_I;
    else                pick = PORT_D;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      last    <= PORT_D;
      win     <= PORT_I;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (i_req || d_req) begin
          win <= pick;
          if (i_req && d_req) last <= pick;
          if (pick == PORT_I) begin
            we_q    <= 1'b0;
            addr_q  <= i_addr;
            wdata_q <= '0;
          end else begin
            we_q    <= d_we;
            addr_q  <= d_addr;
            wdata_q <= d_wdata;
          end
        end
        ACCESS: begin
          err_q   <= acc_err;
          rdata_q <= (acc_err || we_q) ? 32'h0 : mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    i_rvalid  = 1'b0;
    d_rvalid  = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    i_err     = 1'b0;
    d_err     = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    busy      = (state != IDLE);
    case (state)
      IDLE: if (i_req || d_req) state_nxt = ACCESS;
      ACCESS: begin
        state_nxt = RESP;
        i_gnt     = (win == PORT_I);
        d_gnt     = (win == PORT_D);
        if (!acc_err) begin
          mem_addr  = 32'(idx);
          mem_read  = !we_q;
          mem_write = we_q && !rst;
          mem_wdata = wdata_q;
        end
      end
      RESP: begin
        state_nxt = IDLE;
        if (win == PORT_I) begin
          i_rvalid = 1'b1;
          i_rdata  = rdata_q;
          i_err    = err_q;
        end else begin
          d_rvalid = 1'b1;
          d_rdata  = rdata_q;
          d_err    = err_q;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
